mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one unified memory port between the pipeline's instruction-fetch side (I) and data side (D). The block sits between the CPU's fetch/MEM-stage request logic and a single-ported memory that moves one 4-word line per access. A multi-cycle FSM sequences each access: it latches the request, holds the memory strobes for MEM_LATENCY cycles, captures the line, then pulses a one-cycle ready to the winning requester. The CPU stalls IF or MEM while the matching ready is low.

Parameters:
WORD_SIZE, 16, bits per word.
MEM_LATENCY, 2, cycles mem_read/mem_write stay asserted per access; legal range 1..15.

Ports:
Clk  in  1  clock; all state changes on posedge.
Reset_N  in  1  asynchronous, active-low reset.
i_req  in  1  fetch request; held until i_ready.
i_addr  in  16  fetch line address.
i_ready  out  1  one-cycle pulse; i_data valid in that cycle.
i_data  out  64  fetched line; word0 is bits [15:0].
d_req  in  1  data request; held until d_ready.
d_we  in  1  1 = write, 0 = read.
d_addr  in  16  data line address.
d_wdata  in  64  write line.
d_ready  out  1  one-cycle pulse; access complete.
d_rdata  out  64  read line.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
mem_addr  out  16  latched access address.
mem_wdata  out  64  latched write line.
mem_rdata  in  64  memory read line.
busy  out  1  1 when the FSM is not IDLE.
grant_d  out  1  owner of the current or last access (1 = D).

Behaviour:
- Clock port is Clk; reset port is Reset_N. One clock; reset is asynchronous and active-low.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If either req is high at the posedge: pick the owner and latch addr, we and wdata. Load the counter with MEM_LATENCY-1 and go to ACCESS.
  - If neither req is high: stay in IDLE.
- ACCESS:
  - mem_read = !latched_we; mem_write = latched_we. Both are registered outputs.
  - mem_addr and mem_wdata hold the latched values.
  - At the posedge where the counter is 0: a read captures mem_rdata into the owner's response register, then the FSM goes to RESP. Otherwise the counter decrements.
- RESP:
  - Owner's ready = 1 for exactly one cycle; strobes = 0.
  - Always returns to IDLE. Requests are not sampled in RESP.
- Timing:
  - Request sampled at edge 0 → strobes high in cycles 1..MEM_LATENCY → ready in cycle MEM_LATENCY+1.
  - Peak throughput is one access per MEM_LATENCY+2 cycles.
- Requester rule: update req/addr on the edge where ready is seen high. req must not be withdrawn before ready; behaviour if it is withdrawn early is undefined.
- Fixed priority: D beats I when both are high in IDLE.
- Writes pulse d_ready and leave d_rdata unchanged. Reads never modify the other side's response register.
- i_data/d_rdata hold the last captured line until the next capture.
- Inputs are ignored outside IDLE; changing them mid-access has no effect.
- Reset (any state, including mid-ACCESS): state = IDLE; mem_read, mem_write, i_ready, d_ready, busy, grant_d = 0; mem_addr, mem_wdata, i_data, d_rdata = 0; counter = 0. No pending access survives reset.

Optional Feature:
ARB_RR_EN
- Defined: on a tie in IDLE, grant the side not served last. last_owner resets to I, so the first tie after reset goes to D. A single requester is always granted.
- Undefined: fixed D priority; I can starve while d_req stays high.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - owner constants OWN_I = 0, OWN_D = 1;
  - LINE_WORDS = 4 and LINE_BITS = 64.
- Sub-module arb_pick: combinational winner select from i_req, d_req and last_owner. Contains the ARB_RR_EN variant.
- FSM, counter and latches stay in mem_port_arbiter.

Test Plan (MEM_LATENCY = 2 unless noted):
- I read 0x0010, mem_rdata = 0x4444_3333_2222_1111 → mem_read high cycles 1-2 with mem_addr 0x0010; i_ready pulses in cycle 3 with i_data = that value; d_ready stays 0.
- I 0x0020 and D read 0x0100 requested together at edge 0 → mem_addr 0x0100 first; d_ready in cycle 3; I sampled in cycle 4; mem_addr 0x0020 in cycles 5-6; i_ready in cycle 7.
- D write 0x0200, d_wdata = 0xAAAA_BBBB_CCCC_DDDD → mem_write high 2 cycles with mem_wdata equal to d_wdata; mem_read stays 0; d_ready pulses in cycle 3; d_rdata unchanged.
- Reset_N low in cycle 1 of an ACCESS → mem_read, busy and grant_d drop immediately; no ready pulses after release; a new I request after release completes in 3 cycles.
- Both reqs held continuously → with ARB_RR_EN, grant sequence D, I, D, I; without it, D, D, D and i_ready never pulses.
- MEM_LATENCY = 1, single D read → mem_read high in cycle 1 only; d_ready in cycle 2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM states, owner encoding and line geometry shared by the memory port arbiter.
// Pure declarations: no latency and no flow control of its own.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int LINE_WORDS = 4;
    localparam int LINE_BITS  = 64;
    // Strobe counter width covers the MEM_LATENCY range 1..15.
    localparam int CNT_W      = 4;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational fetch/data winner select; zero latency, stateless, grant only when a request is high.
// Default build gives D fixed priority; with ARB_RR_EN defined a tie goes to the side not served last.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic last_owner_i,
    output logic grant_vld_o,
    output logic grant_own_o
);
    assign grant_vld_o = i_req_i | d_req_i;

`ifdef ARB_RR_EN
    always_comb begin
        grant_own_o = d_req_i ? OWN_D : OWN_I;
        if (i_req_i && d_req_i) begin
            grant_own_o = (last_owner_i == OWN_D) ? OWN_I : OWN_D;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;
    assign grant_own_o       = d_req_i ? OWN_D : OWN_I;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port between fetch (I) and data (D); MEM_LATENCY strobe cycles then a 1-cycle ready.
// Requesters hold req until their ready pulse; requests are only sampled in IDLE. ARB_RR_EN selects alternating tie-break.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                            Clk,
    input  logic                            Reset_N,
    input  logic                            i_req,
    input  logic [15:0]                     i_addr,
    output logic                            i_ready,
    output logic [LINE_WORDS*WORD_SIZE-1:0] i_data,
    input  logic                            d_req,
    input  logic                            d_we,
    input  logic [15:0]                     d_addr,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] d_wdata,
    output logic                            d_ready,
    output logic [LINE_WORDS*WORD_SIZE-1:0] d_rdata,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [15:0]                     mem_addr,
    output logic [LINE_WORDS*WORD_SIZE-1:0] mem_wdata,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata,
    output logic                            busy,
    output logic                            grant_d
);
    localparam int LW = LINE_WORDS * WORD_SIZE;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             own_q, own_d;
    logic             we_q, we_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             irdy_q, irdy_d;
    logic             drdy_q, drdy_d;
    logic [15:0]      addr_q, addr_d;
    logic [LW-1:0]    wdata_q, wdata_d;
    logic [LW-1:0]    idata_q, idata_d;
    logic [LW-1:0]    drdata_q, drdata_d;
    logic             grant_vld;
    logic             grant_own;

    // The owner register doubles as "last served" for the tie-break.
    arb_pick u_pick (
        .i_req_i      (i_req),
        .d_req_i      (d_req),
        .last_owner_i (own_q),
        .grant_vld_o  (grant_vld),
        .grant_own_o  (grant_own)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        own_d    = own_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        idata_d  = idata_q;
        drdata_d = drdata_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        irdy_d   = 1'b0;
        drdy_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = ACCESS;
                    own_d   = grant_own;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                    if (grant_own == OWN_D) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                    end
                    rd_d = ~we_d;
                    wr_d = we_d;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (own_q == OWN_D) drdata_d = mem_rdata;
                        else                idata_d  = mem_rdata;
                    end
                    irdy_d = (own_q == OWN_I);
                    drdy_d = (own_q == OWN_D);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    rd_d  = ~we_q;
                    wr_d  = we_q;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            own_q    <= OWN_I;
            we_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            irdy_q   <= 1'b0;
            drdy_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            idata_q  <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            own_q    <= own_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            irdy_q   <= irdy_d;
            drdy_q   <= drdy_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            idata_q  <= idata_d;
            drdata_q <= drdata_d;
        end
    end

    assign mem_read  = rd_q;
    assign mem_write = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_ready   = irdy_q;
    assign d_ready   = drdy_q;
    assign i_data    = idata_q;
    assign d_rdata   = drdata_q;
    assign busy      = (state_q != IDLE);
    assign grant_d   = own_q;
endmodule
